// File: rtl/dma_burst_if.sv
// Burst request/ack channel between the burst streamer and the AXI master,
// plus the FIFO credit, write-response and error return signals.
interface dma_burst_if #(
   parameter int BYTES_PER_BEAT = 8
);
   logic                      rd_valid_o;
   logic                      rd_ready_i;
   logic [31:0]               rd_addr_o;
   logic                      wr_valid_o;
   logic                      wr_ready_i;
   logic [31:0]               wr_addr_o;
   logic [7:0]                alen_o;
   logic [2:0]                size_o;
   logic [BYTES_PER_BEAT-1:0] strb_o;
   logic                      fifo_pop_i;
   logic                      wr_resp_i;
   logic                      axi_rd_err_i;
   logic                      axi_wr_err_i;

   modport master (
      output rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, alen_o, size_o, strb_o,
      input  rd_ready_i, wr_ready_i, fifo_pop_i, wr_resp_i, axi_rd_err_i, axi_wr_err_i
   );

   modport slave (
      input  rd_valid_o, rd_addr_o, wr_valid_o, wr_addr_o, alen_o, size_o, strb_o,
      output rd_ready_i, wr_ready_i, fifo_pop_i, wr_resp_i, axi_rd_err_i, axi_wr_err_i
   );
endinterface

// File: rtl/dma_burst_streamer.sv
// Splits one DMA descriptor into paired read/write burst requests, bounded by
// the 4KB page, the burst length limit and the data FIFO credit.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for go_i; descriptor latched and checked on go
// S_CALC   | size the next burst (one cycle)
// S_RD_REQ | read request, held until credit suffices and it is accepted
// S_WR_REQ | write request, held until accepted; addresses advance
// S_DRAIN  | all bursts issued, waiting for outstanding write responses
// S_DONE   | one cycle; sets sticky done, then back to idle
module dma_burst_streamer #(
   parameter int BYTES_PER_BEAT = 8,
   parameter int MAX_BEATS      = 256,
   parameter int FIFO_DEPTH     = 16,
   parameter int BYTES_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   go_i,
   input  logic [31:0]            src_addr_i,
   input  logic [31:0]            dst_addr_i,
   input  logic [BYTES_WIDTH-1:0] num_bytes_i,
   dma_burst_if.master            bus,
   output logic                   active_o,
   output logic                   done_o,
   output logic                   err_valid_o,
   output logic [1:0]             err_src_o,
   output logic [31:0]            err_addr_o
);

   localparam int BPB_LOG = $clog2(BYTES_PER_BEAT);
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CALC, S_RD_REQ, S_WR_REQ, S_DRAIN, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            src_q, dst_q;
   logic [BYTES_WIDTH-1:0] rem_q, rem_next;
   logic [8:0]             chunk_q, chunk_d;
   logic [CW-1:0]          credit_q;
   logic [15:0]            credit_nxt;
   logic [7:0]             outst_q;
   logic                   done_q, err_q;
   logic [1:0]             err_src_q;
   logic [31:0]            err_addr_q;

   logic src_mis, dst_mis, len_mis, misaligned;
   logic rd_hs, wr_hs, abort;

   function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

   assign src_mis    = (src_addr_i & 32'(BYTES_PER_BEAT - 1)) != 32'd0;
   assign dst_mis    = (dst_addr_i & 32'(BYTES_PER_BEAT - 1)) != 32'd0;
   assign len_mis    = (num_bytes_i & BYTES_WIDTH'(BYTES_PER_BEAT - 1)) != '0;
   assign misaligned = src_mis | dst_mis | len_mis;

   // Beats left before either address crosses its 4KB page.
   always_comb begin
      logic [31:0] src_room, dst_room;
      src_room = (32'd4096 - {20'd0, src_q[11:0]}) >> BPB_LOG;
      dst_room = (32'd4096 - {20'd0, dst_q[11:0]}) >> BPB_LOG;
      chunk_d  = 9'(min32(min32(32'(rem_q), 32'(MAX_BEATS)),
                          min32(32'(FIFO_DEPTH), min32(src_room, dst_room))));
   end

   assign bus.rd_valid_o = (state_q == S_RD_REQ) && (16'(credit_q) >= 16'(chunk_q));
   assign bus.wr_valid_o = (state_q == S_WR_REQ);
   assign bus.rd_addr_o  = src_q;
   assign bus.wr_addr_o  = dst_q;
   assign bus.alen_o     = 8'(chunk_q - 9'd1);
   assign bus.size_o     = 3'(BPB_LOG);
   assign bus.strb_o     = '1;

   assign rd_hs    = bus.rd_valid_o & bus.rd_ready_i;
   assign wr_hs    = bus.wr_valid_o & bus.wr_ready_i;
   assign abort    = err_q | bus.axi_rd_err_i | bus.axi_wr_err_i;
   assign rem_next = rem_q - BYTES_WIDTH'(chunk_q);

   assign credit_nxt = 16'(credit_q) - (rd_hs ? 16'(chunk_q) : 16'd0) + 16'(bus.fifo_pop_i);

   assign active_o    = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o      = done_q;
   assign err_valid_o = err_q;
   assign err_src_o   = err_src_q;
   assign err_addr_o  = err_addr_q;

   // On error a request already on the bus is held until accepted, then we quit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (go_i) state_d = (misaligned || num_bytes_i == '0) ? S_DONE : S_CALC;
         S_CALC:   state_d = abort ? S_DONE : S_RD_REQ;
         S_RD_REQ: begin
            if (rd_hs)                        state_d = abort ? S_DONE : S_WR_REQ;
            else if (abort && !bus.rd_valid_o) state_d = S_DONE;
         end
         S_WR_REQ: if (wr_hs) state_d = abort ? S_DONE :
                                        (rem_next != '0) ? S_CALC : S_DRAIN;
         S_DRAIN:  if (abort || outst_q == 8'd0) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         chunk_q    <= 9'd1;
         credit_q   <= CW'(FIFO_DEPTH);
         outst_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_src_q  <= '0;
         err_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         credit_q <= (credit_nxt > 16'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : credit_nxt[CW-1:0];

         case ({wr_hs, bus.wr_resp_i})
            2'b10:   outst_q <= outst_q + 8'd1;
            2'b01:   if (outst_q != 8'd0) outst_q <= outst_q - 8'd1;
            default: ;
         endcase

         if (state_q == S_IDLE && go_i) begin
            src_q  <= src_addr_i;
            dst_q  <= dst_addr_i;
            rem_q  <= num_bytes_i >> BPB_LOG;
            done_q <= 1'b0;
            err_q  <= misaligned;
            if (misaligned) begin
               err_src_q  <= 2'd2;
               err_addr_q <= src_mis ? src_addr_i :
                             dst_mis ? dst_addr_i : 32'(num_bytes_i);
            end
         end

         if (state_q == S_CALC) chunk_q <= chunk_d;

         if (wr_hs) begin
            src_q <= src_q + (32'(chunk_q) << BPB_LOG);
            dst_q <= dst_q + (32'(chunk_q) << BPB_LOG);
            rem_q <= rem_next;
         end

         if (state_q == S_DONE) done_q <= 1'b1;

         // First error of a transfer is the one reported.
         if (state_q != S_IDLE && !err_q && (bus.axi_rd_err_i || bus.axi_wr_err_i)) begin
            err_q      <= 1'b1;
            err_src_q  <= bus.axi_rd_err_i ? 2'd0 : 2'd1;
            err_addr_q <= bus.axi_rd_err_i ? src_q : dst_q;
         end
      end
   end

endmodule

// File: tb/tb_dma_burst_streamer.sv
// Directed bench for dma_burst_streamer: hand-computed burst addresses,
// lengths, credit stalls, error reporting and reset recovery.
module tb_dma_burst_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        go_i;
   logic [31:0] src_addr_i, dst_addr_i, num_bytes_i;
   logic        active_o, done_o, err_valid_o;
   logic [1:0]  err_src_o;
   logic [31:0] err_addr_o;

   int n_tests = 0;
   int n_fail  = 0;

   dma_burst_if #(.BYTES_PER_BEAT(8)) bus ();

   dma_burst_streamer #(
      .BYTES_PER_BEAT(8), .MAX_BEATS(256), .FIFO_DEPTH(16), .BYTES_WIDTH(32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .go_i        (go_i),
      .src_addr_i  (src_addr_i),
      .dst_addr_i  (dst_addr_i),
      .num_bytes_i (num_bytes_i),
      .bus         (bus.master),
      .active_o    (active_o),
      .done_o      (done_o),
      .err_valid_o (err_valid_o),
      .err_src_o   (err_src_o),
      .err_addr_o  (err_addr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      go_i = 1'b0;
      src_addr_i = '0; dst_addr_i = '0; num_bytes_i = '0;
      bus.rd_ready_i = 1'b0; bus.wr_ready_i = 1'b0; bus.fifo_pop_i = 1'b0;
      bus.wr_resp_i = 1'b0; bus.axi_rd_err_i = 1'b0; bus.axi_wr_err_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] nb);
      src_addr_i = src; dst_addr_i = dst; num_bytes_i = nb;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
   endtask

   task automatic do_rd(input string tag, input logic [31:0] addr, input logic [31:0] alen);
      int n = 0;
      while (!bus.rd_valid_o && n < 50) begin @(negedge clk); n++; end
      check({tag, "_valid"}, 32'(bus.rd_valid_o), 32'd1);
      check({tag, "_addr"}, bus.rd_addr_o, addr);
      check({tag, "_alen"}, 32'(bus.alen_o), alen);
      bus.rd_ready_i = 1'b1;
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
   endtask

   task automatic do_wr(input string tag, input logic [31:0] addr, input logic [31:0] alen);
      int n = 0;
      while (!bus.wr_valid_o && n < 50) begin @(negedge clk); n++; end
      check({tag, "_valid"}, 32'(bus.wr_valid_o), 32'd1);
      check({tag, "_addr"}, bus.wr_addr_o, addr);
      check({tag, "_alen"}, 32'(bus.alen_o), alen);
      bus.wr_ready_i = 1'b1;
      @(negedge clk);
      bus.wr_ready_i = 1'b0;
   endtask

   task automatic pulse_resp();
      bus.wr_resp_i = 1'b1;
      @(negedge clk);
      bus.wr_resp_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic exp_err,
                            input logic [1:0] exp_src, input logic [31:0] exp_addr);
      int n = 0;
      while (!done_o && n < 50) begin @(negedge clk); n++; end
      check({tag, "_done"}, 32'(done_o), 32'd1);
      check({tag, "_err"}, 32'(err_valid_o), 32'(exp_err));
      if (exp_err) begin
         check({tag, "_esrc"}, 32'(err_src_o), 32'(exp_src));
         check({tag, "_eaddr"}, err_addr_o, exp_addr);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic saw;

      // reset state
      reset_dut();
      check("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
      check("rst_wr_valid", 32'(bus.wr_valid_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_valid_o), 32'd0);
      check("rst_active", 32'(active_o), 32'd0);
      check("rst_strb", 32'(bus.strb_o), 32'hFF);
      check("rst_size", 32'(bus.size_o), 32'd3);

      // 1: single 16-beat burst
      start(32'h1000, 32'h2000, 32'd128);
      do_rd("t1_rd", 32'h1000, 32'd15);
      do_wr("t1_wr", 32'h2000, 32'd15);
      repeat (3) @(negedge clk);
      check("t1_wait_resp", 32'(done_o), 32'd0);
      check("t1_active", 32'(active_o), 32'd1);
      pulse_resp();
      wait_done("t1", 1'b0, 2'd0, 32'd0);
      check("t1_idle", 32'(active_o), 32'd0);

      // 2: 4KB crossing on source splits into 2 + 6 beats
      reset_dut();
      start(32'h0FF0, 32'h3000, 32'd64);
      do_rd("t2_rd0", 32'h0FF0, 32'd1);
      do_wr("t2_wr0", 32'h3000, 32'd1);
      do_rd("t2_rd1", 32'h1000, 32'd5);
      do_wr("t2_wr1", 32'h3010, 32'd5);
      pulse_resp();
      repeat (2) @(negedge clk);
      check("t2_one_resp", 32'(done_o), 32'd0);
      pulse_resp();
      wait_done("t2", 1'b0, 2'd0, 32'd0);

      // 3: credit stall until the FIFO drains 16 beats
      reset_dut();
      start(32'h1000, 32'h2000, 32'd256);
      do_rd("t3_rd0", 32'h1000, 32'd15);
      do_wr("t3_wr0", 32'h2000, 32'd15);
      saw = 1'b0;
      repeat (5) begin saw |= bus.rd_valid_o; @(negedge clk); end
      check("t3_stall", 32'(saw), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bus.fifo_pop_i = 1'b1;
         @(negedge clk);
         if (i == 14) check("t3_15pops", 32'(bus.rd_valid_o), 32'd0);
      end
      bus.fifo_pop_i = 1'b0;
      check("t3_16pops", 32'(bus.rd_valid_o), 32'd1);
      do_rd("t3_rd1", 32'h1080, 32'd15);
      do_wr("t3_wr1", 32'h2080, 32'd15);
      pulse_resp();
      pulse_resp();
      wait_done("t3", 1'b0, 2'd0, 32'd0);

      // 4: misaligned descriptors, first offender reported
      reset_dut();
      start(32'h1004, 32'h2000, 32'd128);
      saw = 1'b0;
      repeat (4) begin saw |= bus.rd_valid_o | bus.wr_valid_o; @(negedge clk); end
      check("t4_no_req", 32'(saw), 32'd0);
      wait_done("t4_src", 1'b1, 2'd2, 32'h1004);
      start(32'h1000, 32'h200C, 32'h44);
      wait_done("t4_dst", 1'b1, 2'd2, 32'h200C);
      start(32'h1000, 32'h2000, 32'h13);
      wait_done("t4_len", 1'b1, 2'd2, 32'h13);

      // 5: zero length, then go_i ignored while active
      start(32'h1000, 32'h2000, 32'd0);
      check("t5_done_early", 32'(done_o), 32'd0);
      check("t5_err_clr", 32'(err_valid_o), 32'd0);
      @(negedge clk);
      check("t5_done", 32'(done_o), 32'd1);
      check("t5_no_rd", 32'(bus.rd_valid_o), 32'd0);
      start(32'h1000, 32'h2000, 32'd128);
      @(negedge clk);
      start(32'h1004, 32'h5000, 32'd0);
      check("t5_ign_addr", bus.rd_addr_o, 32'h1000);
      check("t5_ign_err", 32'(err_valid_o), 32'd0);
      check("t5_ign_active", 32'(active_o), 32'd1);
      do_rd("t5_rd", 32'h1000, 32'd15);
      do_wr("t5_wr", 32'h2000, 32'd15);
      pulse_resp();
      wait_done("t5", 1'b0, 2'd0, 32'd0);

      // 6: reset during WR_REQ, then a clean transfer with full credit
      reset_dut();
      start(32'h1000, 32'h2000, 32'd128);
      do_rd("t6_rd", 32'h1000, 32'd15);
      check("t6_in_wr", 32'(bus.wr_valid_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_rd", 32'(bus.rd_valid_o), 32'd0);
      check("t6_rst_wr", 32'(bus.wr_valid_o), 32'd0);
      check("t6_rst_active", 32'(active_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      start(32'h4000, 32'h6000, 32'd128);
      check("t6_lat1", 32'(bus.rd_valid_o), 32'd0);
      @(negedge clk);
      check("t6_lat2", 32'(bus.rd_valid_o), 32'd1);
      do_rd("t6_rd2", 32'h4000, 32'd15);
      do_wr("t6_wr2", 32'h6000, 32'd15);
      pulse_resp();
      wait_done("t6", 1'b0, 2'd0, 32'd0);

      // 7: write error while a read request is pending
      reset_dut();
      start(32'h1000, 32'h2000, 32'd128);
      @(negedge clk);
      bus.axi_wr_err_i = 1'b1;
      @(negedge clk);
      bus.axi_wr_err_i = 1'b0;
      check("t7_hold", 32'(bus.rd_valid_o), 32'd1);
      check("t7_err", 32'(err_valid_o), 32'd1);
      bus.rd_ready_i = 1'b1;
      @(negedge clk);
      bus.rd_ready_i = 1'b0;
      saw = 1'b0;
      repeat (3) begin saw |= bus.wr_valid_o | bus.rd_valid_o; @(negedge clk); end
      check("t7_no_wr", 32'(saw), 32'd0);
      wait_done("t7", 1'b1, 2'd1, 32'h2000);

      // 8: simultaneous errors, read wins
      reset_dut();
      start(32'h1000, 32'h2000, 32'd128);
      bus.axi_rd_err_i = 1'b1;
      bus.axi_wr_err_i = 1'b1;
      @(negedge clk);
      bus.axi_rd_err_i = 1'b0;
      bus.axi_wr_err_i = 1'b0;
      check("t8_no_rd", 32'(bus.rd_valid_o), 32'd0);
      wait_done("t8", 1'b1, 2'd0, 32'h1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
